// File: rtl/operand_forward_stage_if.sv
// R->C boundary bus: R-stage operands/control in, hazard-unit controls in,
// forwarded C-stage operands, issue/held status and performance counters out.
interface operand_forward_stage_if #(
   parameter int unsigned WORD_SIZE  = 32,
   parameter int unsigned CTRL_WIDTH = 16,
   parameter int unsigned CNT_WIDTH  = 32
);
   localparam int unsigned ADR_WIDTH = $clog2(WORD_SIZE);

   logic                  valid_R;
   logic [WORD_SIZE-1:0]  rs1Data_R;
   logic [WORD_SIZE-1:0]  rs2Data_R;
   logic [WORD_SIZE-1:0]  imm_R;
   logic [ADR_WIDTH-1:0]  rd1Adr_R;
   logic [CTRL_WIDTH-1:0] ctrl_R;
   logic [1:0]            rs1ForwardSrc;
   logic [1:0]            rs2ForwardSrc;
   logic [WORD_SIZE-1:0]  computeResult_M;
   logic [WORD_SIZE-1:0]  truncatedResult_W;
   logic                  stallRC;
   logic                  flushRC;
   logic                  flushCM;

   logic                  valid_C;
   logic                  issue_C;
   logic [WORD_SIZE-1:0]  rs1Op_C;
   logic [WORD_SIZE-1:0]  rs2Op_C;
   logic [WORD_SIZE-1:0]  imm_C;
   logic [ADR_WIDTH-1:0]  rd1Adr_C;
   logic [CTRL_WIDTH-1:0] ctrl_C;
   logic                  held_C;
   logic [CNT_WIDTH-1:0]  stallCount;
   logic [CNT_WIDTH-1:0]  bubbleCount;

   modport master (
      output valid_R, rs1Data_R, rs2Data_R, imm_R, rd1Adr_R, ctrl_R,
             rs1ForwardSrc, rs2ForwardSrc, computeResult_M, truncatedResult_W,
             stallRC, flushRC, flushCM,
      input  valid_C, issue_C, rs1Op_C, rs2Op_C, imm_C, rd1Adr_C, ctrl_C,
             held_C, stallCount, bubbleCount
   );

   modport slave (
      input  valid_R, rs1Data_R, rs2Data_R, imm_R, rd1Adr_R, ctrl_R,
             rs1ForwardSrc, rs2ForwardSrc, computeResult_M, truncatedResult_W,
             stallRC, flushRC, flushCM,
      output valid_C, issue_C, rs1Op_C, rs2Op_C, imm_C, rd1Adr_C, ctrl_C,
             held_C, stallCount, bubbleCount
   );
endinterface

// File: rtl/operand_forward_stage.sv
// R->C pipeline register with operand forwarding, stall capture, flush and
// load-use bubble gating, plus saturating stall/bubble counters.
module operand_forward_stage #(
   parameter int unsigned WORD_SIZE  = 32,
   parameter int unsigned CTRL_WIDTH = 16,
   parameter int unsigned CNT_WIDTH  = 32
) (
   input logic                  clk,
   input logic                  reset,
   operand_forward_stage_if.slave bus
);
   localparam int unsigned ADR_WIDTH = $clog2(WORD_SIZE);

   typedef enum logic {RUN = 1'b0, HELD = 1'b1} state_t;

   state_t                state;
   logic                  valid_q;
   logic [WORD_SIZE-1:0]  rs1_q;
   logic [WORD_SIZE-1:0]  rs2_q;
   logic [WORD_SIZE-1:0]  imm_q;
   logic [ADR_WIDTH-1:0]  rd_q;
   logic [CTRL_WIDTH-1:0] ctrl_q;
   logic [CNT_WIDTH-1:0]  stall_cnt;
   logic [CNT_WIDTH-1:0]  bubble_cnt;
   logic [WORD_SIZE-1:0]  rs1_fwd;
   logic [WORD_SIZE-1:0]  rs2_fwd;
   logic                  stall_hit;
   logic                  bubble_hit;

   function automatic logic [WORD_SIZE-1:0] fwd_mux(input logic [1:0]           sel,
                                                    input logic [WORD_SIZE-1:0] stored,
                                                    input logic [WORD_SIZE-1:0] compute,
                                                    input logic [WORD_SIZE-1:0] truncated);
      case (sel)
         2'b01:   return compute;
         2'b10:   return truncated;
         default: return stored;
      endcase
   endfunction

   assign rs1_fwd    = fwd_mux(bus.rs1ForwardSrc, rs1_q, bus.computeResult_M, bus.truncatedResult_W);
   assign rs2_fwd    = fwd_mux(bus.rs2ForwardSrc, rs2_q, bus.computeResult_M, bus.truncatedResult_W);
   assign stall_hit  = bus.stallRC & valid_q;
   assign bubble_hit = bus.flushCM & valid_q;

   // Flush outranks stall; a stall recaptures the forwarded operands so the
   // value survives its producer leaving M/W.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= RUN;
         valid_q <= 1'b0;
         rs1_q   <= '0;
         rs2_q   <= '0;
         imm_q   <= '0;
         rd_q    <= '0;
         ctrl_q  <= '0;
      end else if (bus.flushRC) begin
         state   <= RUN;
         valid_q <= 1'b0;
         rs1_q   <= bus.rs1Data_R;
         rs2_q   <= bus.rs2Data_R;
         imm_q   <= bus.imm_R;
         rd_q    <= bus.rd1Adr_R;
         ctrl_q  <= bus.ctrl_R;
      end else if (bus.stallRC) begin
         state   <= valid_q ? HELD : RUN;
         rs1_q   <= rs1_fwd;
         rs2_q   <= rs2_fwd;
      end else begin
         state   <= RUN;
         valid_q <= bus.valid_R;
         rs1_q   <= bus.rs1Data_R;
         rs2_q   <= bus.rs2Data_R;
         imm_q   <= bus.imm_R;
         rd_q    <= bus.rd1Adr_R;
         ctrl_q  <= bus.ctrl_R;
      end
   end

   // Saturating performance counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt  <= '0;
         bubble_cnt <= '0;
      end else begin
         if (stall_hit && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_WIDTH'(1);
         end
         if (bubble_hit && (bubble_cnt != '1)) begin
            bubble_cnt <= bubble_cnt + CNT_WIDTH'(1);
         end
      end
   end

   assign bus.valid_C     = valid_q;
   assign bus.issue_C     = valid_q & ~bus.flushCM;
   assign bus.rs1Op_C     = rs1_fwd;
   assign bus.rs2Op_C     = rs2_fwd;
   assign bus.imm_C       = imm_q;
   assign bus.rd1Adr_C    = rd_q;
   assign bus.ctrl_C      = ctrl_q;
   assign bus.held_C      = (state == HELD);
   assign bus.stallCount  = stall_cnt;
   assign bus.bubbleCount = bubble_cnt;
endmodule
